// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: shadow-buffered, frame-atomic switch-setting loader for the 8x8 Benes network (optional parity: BENES_CFG_PARITY_EN)
module benes_cfg_loader #(
    parameter int NUM_STAGES   = 5,
    parameter int SW_PER_STAGE = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [SW_PER_STAGE-1:0]                   cfg_data,
    input  logic                                      cfg_par,
    input  logic                                      cfg_flush,
    input  logic                                      frame_sync,
    output logic [0:NUM_STAGES-1][SW_PER_STAGE-1:0]   stage_set,
    output logic                                      commit_pulse,
    output logic                                      cfg_busy,
    output logic                                      cfg_err
);
    localparam int CW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_STAGES - 1);
    typedef enum logic {LOAD, PEND} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [0:NUM_STAGES-1][SW_PER_STAGE-1:0] shadow;
    logic beat, bad, commit;
    assign cfg_ready = state == LOAD && !cfg_flush && !rst;
    assign beat      = cfg_valid && cfg_ready;
    assign cfg_busy  = cnt != '0 || state == PEND;
`ifdef BENES_CFG_PARITY_EN
    assign bad = ^{cfg_data, cfg_par};
    // sticky parity error, cleared only by reset
    always_ff @(posedge clk)
        if (rst) cfg_err <= 1'b0;
        else if (beat && bad) cfg_err <= 1'b1;
`else
    logic unused_par;
    assign unused_par = cfg_par;
    assign bad        = 1'b0;
    assign cfg_err    = 1'b0;
`endif
    // next state: flush beats everything, a bad beat restarts the load, PEND waits for a frame boundary
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        if (cfg_flush) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else if (state == PEND) begin
            commit    = frame_sync;
            state_nxt = frame_sync ? LOAD : PEND;
        end else if (beat) begin
            cnt_nxt   = (bad || cnt == LAST) ? '0 : cnt + 1'b1;
            state_nxt = (!bad && cnt == LAST) ? PEND : LOAD;
        end
    end
    // control registers
    always_ff @(posedge clk)
        if (rst) begin
            state        <= LOAD;
            cnt          <= '0;
            commit_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            commit_pulse <= commit;
        end
    // shadow buffer fill; contents are irrelevant until a full set is loaded
    always_ff @(posedge clk)
        if (beat && !bad) shadow[cnt] <= cfg_data;
    // active settings change only as a whole, on commit
    always_ff @(posedge clk)
        if (rst) stage_set <= '0;
        else if (commit) stage_set <= shadow;
endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader: directed self-checking bench for benes_cfg_loader
module tb_benes_cfg_loader;
    logic clk = 0, rst = 1, cfg_valid = 0, cfg_par = 0, cfg_flush = 0, frame_sync = 0;
    logic [3:0] cfg_data = '0;
    logic cfg_ready, commit_pulse, cfg_busy, cfg_err;
    logic [0:4][3:0] stage_set;
    int checks = 0, errors = 0;

    benes_cfg_loader dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_par(cfg_par), .cfg_flush(cfg_flush),
        .frame_sync(frame_sync), .stage_set(stage_set), .commit_pulse(commit_pulse),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] pk(input logic [3:0] a, b, c, d, e);
        return {a, b, c, d, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [3:0] d, input logic p);
        cfg_valid = 1;
        cfg_data  = d;
        cfg_par   = p;
        #1;
        chk(tag, cfg_ready, 1);
        tick();
        cfg_valid = 0;
    endtask

    task automatic load5(input string tag, input logic [3:0] a, b, c, d, e);
        send(tag, a, ^a);
        send(tag, b, ^b);
        send(tag, c, ^c);
        send(tag, d, ^d);
        send(tag, e, ^e);
    endtask

    task automatic commit_chk(input string tag, input logic [19:0] exp);
        frame_sync = 1;
        tick();
        frame_sync = 0;
        chk({tag, "_commit"}, commit_pulse, 1);
        chk({tag, "_set"}, stage_set, exp);
        chk({tag, "_busy"}, cfg_busy, 0);
        tick();
        chk({tag, "_pulse_end"}, commit_pulse, 0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_set", stage_set, 0);
        chk("rst_commit", commit_pulse, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_ready", cfg_ready, 0);
        rst = 0;
        #1;
        chk("ready_after_rst", cfg_ready, 1);

        // basic load, commit three cycles after the last beat
        load5("load_ready", 4'h1, 4'h2, 4'h4, 4'h8, 4'hF);
        chk("pend_busy", cfg_busy, 1);
        chk("pend_ready", cfg_ready, 0);
        chk("pend_set_old", stage_set, 0);
        tick();
        tick();
        chk("pend_ready2", cfg_ready, 0);
        chk("pend_no_commit", commit_pulse, 0);
        commit_chk("c1", pk(4'h1, 4'h2, 4'h4, 4'h8, 4'hF));

        // last beat together with frame_sync: ignored, then a held two-cycle frame_sync commits once
        send("lb_ready", 4'h5, 0);
        send("lb_ready", 4'h6, 0);
        send("lb_ready", 4'h7, 1);
        send("lb_ready", 4'h9, 0);
        frame_sync = 1;
        send("lb_ready", 4'hA, 0);
        frame_sync = 0;
        chk("lb_no_commit", commit_pulse, 0);
        chk("lb_set_old", stage_set, pk(4'h1, 4'h2, 4'h4, 4'h8, 4'hF));
        chk("lb_busy", cfg_busy, 1);
        tick();
        tick();
        tick();
        chk("lb_still_old", stage_set, pk(4'h1, 4'h2, 4'h4, 4'h8, 4'hF));
        frame_sync = 1;
        tick();
        chk("lb_commit", commit_pulse, 1);
        chk("lb_set", stage_set, pk(4'h5, 4'h6, 4'h7, 4'h9, 4'hA));
        tick();
        frame_sync = 0;
        chk("lb_single_commit", commit_pulse, 0);
        chk("lb_ready_after", cfg_ready, 1);

        // flush during load drops the partial set; the beat offered with flush is refused
        send("fl_ready", 4'hA, 0);
        send("fl_ready", 4'hA, 0);
        send("fl_ready", 4'hA, 0);
        cfg_flush = 1;
        cfg_valid = 1;
        cfg_data  = 4'h5;
        #1;
        chk("fl_refused", cfg_ready, 0);
        tick();
        cfg_flush = 0;
        cfg_valid = 0;
        chk("fl_busy", cfg_busy, 0);
        chk("fl_set_kept", stage_set, pk(4'h5, 4'h6, 4'h7, 4'h9, 4'hA));
        load5("fl_ready2", 4'h3, 4'h3, 4'h3, 4'h3, 4'h3);
        commit_chk("fl", pk(4'h3, 4'h3, 4'h3, 4'h3, 4'h3));

        // flush beats frame_sync in PEND
        load5("flp_ready", 4'hE, 4'hE, 4'hE, 4'hE, 4'hE);
        cfg_flush  = 1;
        frame_sync = 1;
        tick();
        cfg_flush  = 0;
        frame_sync = 0;
        chk("flp_no_commit", commit_pulse, 0);
        chk("flp_set_kept", stage_set, pk(4'h3, 4'h3, 4'h3, 4'h3, 4'h3));
        chk("flp_busy", cfg_busy, 0);

        // reset while pending clears everything; later frame_sync has nothing to commit
        load5("rp_ready", 4'hC, 4'hC, 4'hC, 4'hC, 4'hC);
        rst = 1;
        tick();
        rst = 0;
        chk("rp_set", stage_set, 0);
        chk("rp_busy", cfg_busy, 0);
        frame_sync = 1;
        tick();
        frame_sync = 0;
        chk("rp_no_commit", commit_pulse, 0);
        chk("rp_set2", stage_set, 0);

        // continuous valid and frame_sync: five beats per commit, no loss or duplication
        cfg_valid  = 1;
        frame_sync = 1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 5; i++) begin
                cfg_data = 4'(5 * c + i);
                cfg_par  = ^cfg_data;
                #1;
                chk("bp_ready", cfg_ready, 1);
                tick();
            end
            cfg_data = 4'(5 * c + 5);
            cfg_par  = ^cfg_data;
            #1;
            chk("bp_pend_ready", cfg_ready, 0);
            tick();
            chk("bp_commit", commit_pulse, 1);
            chk("bp_set", stage_set, pk(4'(5 * c), 4'(5 * c + 1), 4'(5 * c + 2), 4'(5 * c + 3), 4'(5 * c + 4)));
        end
        cfg_valid  = 0;
        frame_sync = 0;
        tick();

`ifdef BENES_CFG_PARITY_EN
        // parity error on the third beat restarts the load and latches cfg_err
        send("par_ready", 4'h1, 1);
        send("par_ready", 4'h2, 1);
        send("par_ready", 4'h7, 0);
        chk("par_err", cfg_err, 1);
        chk("par_busy", cfg_busy, 0);
        load5("par_ready2", 4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        commit_chk("par", pk(4'h1, 4'h2, 4'h3, 4'h4, 4'h5));
        chk("par_err_sticky", cfg_err, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("par_err_rst", cfg_err, 0);
`else
        // parity bit is ignored: wrong parity beats are still written
        send("nopar_ready", 4'h1, 0);
        send("nopar_ready", 4'h2, 0);
        send("nopar_ready", 4'h7, 0);
        chk("nopar_busy", cfg_busy, 1);
        send("nopar_ready", 4'h4, 0);
        send("nopar_ready", 4'h5, 1);
        commit_chk("nopar", pk(4'h1, 4'h2, 4'h7, 4'h4, 4'h5));
        chk("nopar_err", cfg_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
